alu_exec_unit: RTL and testbench

Parametrised, multi-cycle execute unit that succeeds the single-cycle ALU control decoder. It decodes ALUOp/funct3/funct7 and executes both RV32I base ALU ops and RV32M multiply/divide ops on XLEN-bit operands. Base ops finish in one cycle; MUL/DIV run on an iterative datapath. The unit sits between the register-read stage and writeback and uses a valid/ready handshake on both sides.

---
 rtl/alu_exec_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- multi-cycle RV32I/RV32M execute unit.
//
// Decodes ALUOp/funct3/funct7, executes base ALU ops in one cycle and
// MUL/DIV ops on an iterative one-bit-per-cycle datapath. Valid/ready
// handshake on the request and result sides; one operation in flight.
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   in_valid/in_ready   request handshake
//   ALUOp, funct3, funct7, op_a, op_b   request fields, captured at transfer
//   out_valid/out_ready result handshake
//   result, zero, illegal  registered outputs, held while out_valid
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR,
    OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM,
    OP_REMU, OP_ILL
  } op_e;

  function automatic op_e base_op(input logic [2:0] f3, input logic sra);
    op_e r;
    r = OP_ADD;
    case (f3)
      3'b000: r = OP_ADD;
      3'b001: r = OP_SLL;
      3'b010: r = OP_SLT;
      3'b011: r = OP_SLTU;
      3'b100: r = OP_XOR;
      3'b101: r = sra ? OP_SRA : OP_SRL;
      3'b110: r = OP_OR;
      default: r = OP_AND;
    endcase
    return r;
  endfunction

  function automatic op_e m_op(input logic [2:0] f3);
    op_e r;
    r = OP_MUL;
    case (f3)
      3'b000: r = OP_MUL;
      3'b001: r = OP_MULH;
      3'b010: r = OP_MULHSU;
      3'b011: r = OP_MULHU;
      3'b100: r = OP_DIV;
      3'b101: r = OP_DIVU;
      3'b110: r = OP_REM;
      default: r = OP_REMU;
    endcase
    return r;
  endfunction

  state_e state, state_nx;
  op_e    dec_op, mop;

  logic [XLEN-1:0]   fast_res, calc_res, mag_a, mag_b, opnd;
  logic [2*XLEN-1:0] acc, step_nx, mul_nx, div_nx, prod_fin;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_rem, quo, rem;
  logic [SW-1:0]     cnt;
  logic              neg, div_ok, div_zero, div_ovf, dec_iter, dec_mul, dec_div;
  logic              a_neg, b_neg, mop_mul;

  // ---------------- decode ----------------
  always_comb begin
    dec_op = OP_ILL;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (funct7)
          7'b0000000: dec_op = base_op(funct3, 1'b0);
          7'b0100000: begin
            if (funct3 == 3'b000)      dec_op = OP_SUB;
            else if (funct3 == 3'b101) dec_op = OP_SRA;
          end
          7'b0000001: dec_op = m_op(funct3);
          default: ;
        endcase
      end
      default: dec_op = base_op(funct3, funct7[5]);
    endcase
  end

  assign dec_mul  = dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign dec_div  = dec_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign div_zero = (op_b == '0);
  // Most negative / -1 only overflows for the signed forms.
  assign div_ovf  = (dec_op inside {OP_DIV, OP_REM}) &&
                    (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign dec_iter = dec_mul || (dec_div && !div_zero && !div_ovf);

  // ---------------- single-cycle results ----------------
  always_comb begin
    fast_res = '0;
    case (dec_op)
      OP_ADD:  fast_res = op_a + op_b;
      OP_SUB:  fast_res = op_a - op_b;
      OP_SLL:  fast_res = op_a << op_b[SW-1:0];
      OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:  fast_res = op_a ^ op_b;
      OP_SRL:  fast_res = op_a >> op_b[SW-1:0];
      OP_SRA:  fast_res = $unsigned($signed(op_a) >>> op_b[SW-1:0]);
      OP_OR:   fast_res = op_a | op_b;
      OP_AND:  fast_res = op_a & op_b;
      // Divide fast path: only reached for divide-by-zero or signed overflow.
      OP_DIV:  fast_res = div_zero ? '1 : op_a;
      OP_DIVU: fast_res = '1;
      OP_REM:  fast_res = div_zero ? op_a : '0;
      OP_REMU: fast_res = op_a;
      default: fast_res = '0;
    endcase
  end

  // ---------------- iterative datapath ----------------
  // Operand signs are only honoured for the signed forms of each op.
  assign a_neg = (dec_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && op_a[XLEN-1];
  assign b_neg = (dec_op inside {OP_MULH, OP_DIV, OP_REM}) && op_b[XLEN-1];
  assign mag_a = a_neg ? -op_a : op_a;
  assign mag_b = b_neg ? -op_b : op_b;

  assign mop_mul = mop inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};

  // Shift-add multiply: acc = {partial sum, remaining multiplier bits}.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nx  = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide: acc = {partial remainder, dividend bits -> quotient}.
  // The new remainder is always below the divisor, so XLEN-bit subtraction
  // is exact once the XLEN+1-bit compare has passed.
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ok    = div_shift >= {1'b0, opnd};
  assign div_rem   = div_ok ? (div_shift[XLEN-1:0] - opnd) : div_shift[XLEN-1:0];
  assign div_nx    = {div_rem, acc[XLEN-2:0], div_ok};

  assign step_nx  = mop_mul ? mul_nx : div_nx;
  assign prod_fin = neg ? -step_nx : step_nx;
  assign quo      = neg ? -step_nx[XLEN-1:0] : step_nx[XLEN-1:0];
  assign rem      = neg ? -step_nx[2*XLEN-1:XLEN] : step_nx[2*XLEN-1:XLEN];

  always_comb begin
    calc_res = '0;
    case (mop)
      OP_MUL:                        calc_res = prod_fin[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  calc_res = prod_fin[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               calc_res = quo;
      default:                       calc_res = rem;
    endcase
  end

  // NOTE: pure datapath registers carry no reset; they are always loaded at
  // launch before being read, and leaving them out of the async-reset block
  // keeps the reset net off the wide accumulator.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid && dec_iter) begin
      mop <= dec_op;
      if (dec_mul) begin
        acc  <= {{XLEN{1'b0}}, mag_b};
        opnd <= mag_a;
        neg  <= a_neg ^ b_neg;
      end else begin
        acc  <= {{XLEN{1'b0}}, mag_a};
        opnd <= mag_b;
        // Remainder takes the dividend's sign, quotient the XOR of both.
        neg  <= (dec_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
      end
    end else if (state == S_CALC) begin
      acc <= step_nx;
    end
  end

  // ---------------- control ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = dec_iter ? S_CALC : S_DONE;
      S_CALC:  if (cnt == '0) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (dec_iter) begin
              cnt     <= SW'(XLEN-1);
              illegal <= 1'b0;
            end else begin
              result  <= fast_res;
              zero    <= (fast_res == '0);
              illegal <= (dec_op == OP_ILL);
            end
          end
        end
        S_CALC: begin
          if (cnt == '0) begin
            result <= calc_res;
            zero   <= (calc_res == '0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (XLEN = 32).
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] aluop, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res,
                              input logic ill, input int lat);
    vec_t v;
    v.aluop = aluop; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
    v.res = res; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // Issues one request (called just after a rising edge) and waits for
  // out_valid. lat is the number of edges from the transfer edge onward.
  task automatic run_op(input logic [1:0] aluop, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    ALUOp = aluop; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs: the unit must use only the values captured at transfer.
    ALUOp = ~aluop; funct3 = ~f3; funct7 = ~f7; op_a = ~a; op_b = b ^ 32'h5A5A_A5A5;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  initial begin
    int   lat;
    bit   seen;
    logic [31:0] held;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
    #12;
    check("reset_in_ready",  {31'b0, in_ready},  32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result",    result,             32'd0);
    check("reset_zero",      {31'b0, zero},      32'd0);
    check("reset_illegal",   {31'b0, illegal},   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    vecs.push_back(mk(2'b00, 3'b000, 7'h00, 32'd5,        32'd7,        32'd12,       1'b0, 1));
    vecs.push_back(mk(2'b01, 3'b000, 7'h00, 32'h1234,     32'h1234,     32'd0,        1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'h24,      32'hF800_0000, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b101, 7'h00, 32'h8000_0000, 32'h24,      32'h0800_0000, 1'b0, 1));
    vecs.push_back(mk(2'b00, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd1,       32'd0,        1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1,       32'd1,        1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1,       32'd0,        1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b100, 7'h00, 32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b110, 7'h00, 32'hF0F0,     32'hFF00,     32'hFFF0,     1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b111, 7'h00, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1));
    vecs.push_back(mk(2'b11, 3'b001, 7'h00, 32'd1,        32'h3F,       32'h8000_0000, 1'b0, 1));
    vecs.push_back(mk(2'b11, 3'b101, 7'h20, 32'h8000_0000, 32'd4,       32'hF800_0000, 1'b0, 1));
    vecs.push_back(mk(2'b11, 3'b000, 7'h20, 32'd10,       32'd3,        32'd13,       1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b000, 7'h7F, 32'd10,       32'd3,        32'd0,        1'b1, 1));
    vecs.push_back(mk(2'b10, 3'b001, 7'h20, 32'd10,       32'd3,        32'd0,        1'b1, 1));
    vecs.push_back(mk(2'b10, 3'b000, 7'h01, 32'hFFFF_FFFF, 32'd3,       32'hFFFF_FFFD, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'd3,       32'd2,        1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b001, 7'h01, 32'hFFFF_FFFF, 32'd3,       32'hFFFF_FFFF, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b010, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b000, 7'h01, 32'hFFFF_FFF9, 32'd3,       32'hFFFF_FFEB, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b100, 7'h01, 32'd7,        32'd0,        32'hFFFF_FFFF, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b110, 7'h01, 32'd7,        32'd0,        32'd7,        1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b101, 7'h01, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b111, 7'h01, 32'd5,        32'd0,        32'd5,        1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,      1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b100, 7'h01, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b110, 7'h01, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b100, 7'h01, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b110, 7'h01, 32'd7,        32'hFFFF_FFFE, 32'd1,       1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b101, 7'h01, 32'd100,      32'd7,        32'd14,       1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b111, 7'h01, 32'd100,      32'd7,        32'd2,        1'b0, 33));

    foreach (vecs[i]) begin
      run_op(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].res == 32'd0});
      check($sformatf("v%0d_illegal", i), {31'b0, illegal}, {31'b0, vecs[i].ill});
      @(posedge clk); #1;
      check($sformatf("v%0d_idle_after", i), {31'b0, in_ready}, 32'd1);
    end

    // Backpressure: DONE must hold its outputs while out_ready is low.
    out_ready = 1'b0;
    run_op(2'b00, 3'b000, 7'h00, 32'd3, 32'd4, lat);
    check("bp_latency", 32'(lat), 32'd1);
    check("bp_result", result, 32'd7);
    held = result;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_hold_result", result, held);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'b0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);

    // Reset ten cycles into a DIVU aborts it with no clock edge.
    ALUOp = 2'b10; funct3 = 3'b101; funct7 = 7'h01; op_a = 32'd100; op_b = 32'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", {31'b0, seen}, 32'd0);
    run_op(2'b00, 3'b000, 7'h00, 32'd2, 32'd2, lat);
    check("post_abort_latency", 32'(lat), 32'd1);
    check("post_abort_result", result, 32'd4);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
